// File: rtl/vol_mem_arbiter.sv
// Owner of the single-port membrane-voltage RAM: sweeps INIT_VAL into every neuron
// slot after reset or start_init, then round-robins hidden-layer (A) and readout (B) accesses.
module vol_mem_arbiter #(
    parameter int          ADDR_W   = 6,
    parameter int          DATA_W   = 16,
    parameter int          DEPTH    = 40,
    parameter int unsigned INIT_VAL = 63
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_init,
    output logic              init_busy,
    input  logic              req_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    input  logic              req_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              gnt_a,
    output logic              gnt_b,
    output logic              rvalid_a,
    output logic              rvalid_b,
    output logic [DATA_W-1:0] rdata,
    output logic              addr_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       stall_cnt,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        RST_WAIT = 2'd0,
        SWEEP    = 2'd1,
        ARB      = 2'd2
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
    localparam logic [DATA_W-1:0] INIT_WORD = DATA_W'(INIT_VAL);

    state_t            state;
    logic [ADDR_W-1:0] sweep_cnt;
    logic              prio_b;
    logic              rd_err_q;

    logic              arb_open;
    logic              granted;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic              win_oor;
    logic              stall;

    // Handshake: a requester holds req/we/addr/wdata until it sees gnt; gnt is
    // combinational and the access is taken in that same cycle. rvalid_x then
    // qualifies rdata for exactly one cycle, one cycle after a granted read.
    assign arb_open = (state == ARB) && !start_init;
    assign gnt_a    = arb_open && req_a && (!req_b || !prio_b);
    assign gnt_b    = arb_open && req_b && (!req_a || prio_b);
    assign granted  = gnt_a || gnt_b;

    assign win_we    = gnt_b ? we_b    : we_a;
    assign win_addr  = gnt_b ? addr_b  : addr_a;
    assign win_wdata = gnt_b ? wdata_b : wdata_a;
    assign win_oor   = {1'b0, win_addr} >= DEPTH_EXT;

    assign addr_err  = granted && win_oor;
    assign init_busy = (state != ARB);
    assign state_dbg = state;

    // A requester that is asserting but not being served this cycle is stalled.
    assign stall = (req_a && !gnt_a) || (req_b && !gnt_b);

    assign rdata = ((rvalid_a || rvalid_b) && !rd_err_q) ? mem_rdata : '0;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state == SWEEP) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = sweep_cnt;
            mem_wdata = INIT_WORD;
        end else if (granted) begin
            mem_en    = !win_oor;
            mem_we    = win_we && !win_oor;
            mem_addr  = win_addr;
            mem_wdata = win_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RST_WAIT;
            sweep_cnt <= '0;
            prio_b    <= 1'b0;
            stall_cnt <= '0;
            rvalid_a  <= 1'b0;
            rvalid_b  <= 1'b0;
            rd_err_q  <= 1'b0;
        end else begin
            case (state)
                RST_WAIT: state <= SWEEP;
                SWEEP: begin
                    // start_init is not looked at here: a sweep always runs to completion.
                    if (sweep_cnt == LAST_IDX) begin
                        sweep_cnt <= '0;
                        state     <= ARB;
                    end else begin
                        sweep_cnt <= sweep_cnt + ADDR_W'(1);
                    end
                end
                ARB: begin
                    if (start_init) begin
                        state <= SWEEP;
                    end
                end
                default: state <= RST_WAIT;
            endcase

            if (granted) begin
                prio_b <= gnt_a;
            end

            if (stall && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end

            rvalid_a <= gnt_a && !we_a;
            rvalid_b <= gnt_b && !we_b;
            rd_err_q <= granted && win_oor && !win_we;
        end
    end

endmodule
